decode_stage: RTL
=================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter PC_W, default 32, meaning program-counter width.
REQ-002 SHALL have parameter IMM_W, default 32, meaning extended-immediate output width (at least 16).
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low. Ports: clk in 1, rising-edge clock; rst_n in 1, asynchronous active-low reset.
REQ-004 SHALL have the following upstream ports:
- in_valid in 1: instruction offered.
- in_ready out 1: stage accepts this cycle.
- in_instr in 32: MIPS instruction word.
- in_pc in PC_W: its PC.
REQ-005 SHALL have the following execute-feedback ports:
- flush in 1: taken branch/jump in EX; discard the decoded instruction.
- ex_mem_read in 1: instruction now in EX is a load.
- ex_rt in 5: load destination register.
REQ-006 SHALL have the following downstream ports:
- out_valid out 1; out_ready in 1: handshake.
- out_pc out PC_W.
- out_rs, out_rt, out_wreg out 5: source and write-back registers.
- out_imm out IMM_W: extended instr[15:0].
- out_alu_ctrl out 6.
- out_signals out 8: [7] ALUSrc, [6] MemToReg, [5] RegWrite, [4] MemRead, [3] MemWrite, [2] branch, [1] eq, [0] goto.
- out_illegal out 1: opcode not in table.

Function
REQ-007 SHALL decode the following opcodes to signals / ALU ctrl / sign:
- 000000 R: 00100000 / instr[5:0] / 0
- 100011 lw: 11110000 / 100000 / 0
- 101011 sw: 10001000 / 100000 / 0
- 000100 beq: 00000110 / 100010 / 1
- 000101 bne: 00000100 / 100010 / 1
- 001000 addi: 10100000 / 100000 / 1
- 001001 addiu: 10100000 / 100001 / 0
- 100101 andi: 10100000 / 100100 / 1
- 100111 ori: 10100000 / 100101 / 1
- 100100 andiu: 10100000 / 100100 / 0
- 100110 oriu: 10100000 / 100101 / 0
- 100010 sltiu: 10100000 / 101011 / 0
- 000001 j: 00000001 / 000000 / 0
- all other opcodes: 00000000 / 000000 / 0 with out_illegal=1.
REQ-008 out_imm SHALL be sign-extended when sign=1 and zero-extended otherwise.
REQ-009 out_wreg SHALL be instr[15:11] for R-type and instr[20:16] otherwise; when out_wreg=0, RegWrite SHALL be forced to 0.
REQ-010 The FSM SHALL have three states: EMPTY, FULL and HOLD (load-use bubble); out_valid=1 only in FULL.
REQ-011 Accept condition SHALL be in_valid && in_ready; in_ready = (state==EMPTY || (state==FULL && out_ready)) && !hazard && !flush.
REQ-012 hazard SHALL be ex_mem_read && ex_rt!=0 && (ex_rt==in_instr[25:21] || (ex_rt==in_instr[20:16] && opcode is neither lw nor j)).
REQ-013 Latency SHALL be 1 cycle: an instruction accepted on edge N appears with out_valid=1 after edge N.
REQ-014 Transitions SHALL be as follows:
- EMPTY or FULL with hazard and in_valid: go to HOLD, out_valid=0.
- HOLD: go to EMPTY next cycle; no accept in HOLD.
- FULL with out_ready and no accept: go to EMPTY.
REQ-015 While out_valid && !out_ready, all out_* SHALL hold stable.
REQ-016 flush SHALL have priority over every event: the next state SHALL be EMPTY and a simultaneous in_valid SHALL NOT be accepted.

Reset
REQ-017 While rst_n=0, the state SHALL be EMPTY and every output SHALL be 0, except in_ready, which SHALL be 1 after reset release when flush=0.
REQ-018 Reset asserted mid-operation SHALL discard a held instruction without emitting it.

Configuration
REQ-019 With DECODE_PERF_EN defined, the block SHALL add output stall_cnt out 16, counting cycles in HOLD plus cycles with out_valid && !out_ready. The counter SHALL saturate at 16'hFFFF and reset to 0.
REQ-020 Without DECODE_PERF_EN, the stall_cnt port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-021 The opcode constants, the signals bit indices and the FSM state typedef SHALL live in the shared package decode_pkg.
REQ-022 The combinational table of REQ-007 to REQ-009 SHALL be a sub-module, decode_table; decode_stage SHALL instantiate it and add the registers, FSM and hazard logic.

Verification
REQ-023 Reset, then present addi $t1,$t0,-1 (0x2109FFFF): next cycle out_valid=1, signals=0xA0, alu=100000, out_imm=0xFFFFFFFF, out_wreg=9.
REQ-024 ex_mem_read=1, ex_rt=8, then present add $3,$8,$2: in_ready=0, one HOLD cycle with out_valid=0, then the instruction is accepted and emitted with wreg=3.
REQ-025 Hold out_ready=0 for 3 cycles with FULL and in_valid=1: outputs stay stable, in_ready=0, no instruction is lost; with PERF, stall_cnt=3.
REQ-026 Assert flush together with in_valid while FULL: next cycle out_valid=0 and the offered instruction is not accepted.
REQ-027 Present opcode 111111: out_illegal=1, signals=0. Present add with rd=0: RegWrite=0.
REQ-028 Drive rst_n low mid-stream: outputs go to 0 immediately and the state is EMPTY.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared constants for the MIPS decode stage: opcodes, control-signal bit
// positions and the pipeline-register FSM state encoding.
package decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b100101;
    localparam logic [5:0] OP_ORI   = 6'b100111;
    localparam logic [5:0] OP_ANDIU = 6'b100100;
    localparam logic [5:0] OP_ORIU  = 6'b100110;
    localparam logic [5:0] OP_SLTIU = 6'b100010;
    localparam logic [5:0] OP_J     = 6'b000001;

    // Bit positions inside out_signals.
    localparam int SIG_ALU_SRC    = 7;
    localparam int SIG_MEM_TO_REG = 6;
    localparam int SIG_REG_WRITE  = 5;
    localparam int SIG_MEM_READ   = 4;
    localparam int SIG_MEM_WRITE  = 3;
    localparam int SIG_BRANCH     = 2;
    localparam int SIG_EQ         = 1;
    localparam int SIG_GOTO       = 0;

    typedef logic [1:0] state_t;
    localparam state_t ST_EMPTY = 2'd0;
    localparam state_t ST_FULL  = 2'd1;
    localparam state_t ST_HOLD  = 2'd2;

endpackage

// File: rtl/decode_if.sv
// Upstream and downstream handshake bundle of the decode stage.
// A transfer happens on a rising edge where valid && ready; valid never waits on ready,
// and once raised, valid and its payload stay stable until that transfer occurs.
interface decode_if #(
    parameter int PC_W  = 32,
    parameter int IMM_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [PC_W-1:0]  in_pc;

    logic             out_valid;
    logic             out_ready;
    logic [PC_W-1:0]  out_pc;
    logic [4:0]       out_rs;
    logic [4:0]       out_rt;
    logic [4:0]       out_wreg;
    logic [IMM_W-1:0] out_imm;
    logic [5:0]       out_alu_ctrl;
    logic [7:0]       out_signals;
    logic             out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_rs, out_rt, out_wreg,
               out_imm, out_alu_ctrl, out_signals, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_rs, out_rt, out_wreg,
               out_imm, out_alu_ctrl, out_signals, out_illegal
    );
endinterface

// File: rtl/decode_table.sv
// Purely combinational MIPS opcode table: control signals, ALU control,
// immediate extension and write-back register selection.
module decode_table
    import decode_pkg::*;
#(
    parameter int IMM_W = 32
) (
    input  logic [31:0]      instr,
    output logic [7:0]       signals,
    output logic [5:0]       alu_ctrl,
    output logic [IMM_W-1:0] imm,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       wreg,
    output logic             illegal
);
    logic [5:0] opcode;
    logic       sign_ext;
    logic [7:0] base_sig;

    assign opcode = instr[31:26];

    always_comb begin
        base_sig = 8'b0000_0000;
        alu_ctrl = 6'b000000;
        sign_ext = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            OP_RTYPE: begin base_sig = 8'b0010_0000; alu_ctrl = instr[5:0]; end
            OP_LW:    begin base_sig = 8'b1111_0000; alu_ctrl = 6'b100000; end
            OP_SW:    begin base_sig = 8'b1000_1000; alu_ctrl = 6'b100000; end
            OP_BEQ:   begin base_sig = 8'b0000_0110; alu_ctrl = 6'b100010; sign_ext = 1'b1; end
            OP_BNE:   begin base_sig = 8'b0000_0100; alu_ctrl = 6'b100010; sign_ext = 1'b1; end
            OP_ADDI:  begin base_sig = 8'b1010_0000; alu_ctrl = 6'b100000; sign_ext = 1'b1; end
            OP_ADDIU: begin base_sig = 8'b1010_0000; alu_ctrl = 6'b100001; end
            OP_ANDI:  begin base_sig = 8'b1010_0000; alu_ctrl = 6'b100100; sign_ext = 1'b1; end
            OP_ORI:   begin base_sig = 8'b1010_0000; alu_ctrl = 6'b100101; sign_ext = 1'b1; end
            OP_ANDIU: begin base_sig = 8'b1010_0000; alu_ctrl = 6'b100100; end
            OP_ORIU:  begin base_sig = 8'b1010_0000; alu_ctrl = 6'b100101; end
            OP_SLTIU: begin base_sig = 8'b1010_0000; alu_ctrl = 6'b101011; end
            OP_J:     begin base_sig = 8'b0000_0001; end
            default:  begin illegal  = 1'b1; end
        endcase
    end

    assign rs   = instr[25:21];
    assign rt   = instr[20:16];
    assign wreg = (opcode == OP_RTYPE) ? instr[15:11] : instr[20:16];

    // Writing $zero is a no-op, so suppress RegWrite rather than let EX try.
    always_comb begin
        signals = base_sig;
        if (wreg == 5'd0) signals[SIG_REG_WRITE] = 1'b0;
    end

    assign imm = sign_ext ? {{(IMM_W-16){instr[15]}}, instr[15:0]}
                          : {{(IMM_W-16){1'b0}}, instr[15:0]};
endmodule

// File: rtl/decode_stage.sv
// MIPS decode pipeline stage: decode table, one-entry output register, load-use
// bubble FSM (EMPTY/FULL/HOLD). Define DECODE_PERF_EN to add the stall_cnt counter.
module decode_stage
    import decode_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int IMM_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    decode_if.slave     bus,
    input  logic        flush,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    output state_t      dbg_state
`ifdef DECODE_PERF_EN
    ,
    output logic [15:0] stall_cnt
`endif
);
    state_t           state;
    state_t           state_nxt;
    logic             hazard;
    logic             in_ready_w;
    logic             accept;

    logic [7:0]       dec_signals;
    logic [5:0]       dec_alu_ctrl;
    logic [IMM_W-1:0] dec_imm;
    logic [4:0]       dec_rs;
    logic [4:0]       dec_rt;
    logic [4:0]       dec_wreg;
    logic             dec_illegal;

    logic [PC_W-1:0]  pc_q;
    logic [4:0]       rs_q;
    logic [4:0]       rt_q;
    logic [4:0]       wreg_q;
    logic [IMM_W-1:0] imm_q;
    logic [5:0]       alu_ctrl_q;
    logic [7:0]       signals_q;
    logic             illegal_q;

    decode_table #(.IMM_W(IMM_W)) u_table (
        .instr    (bus.in_instr),
        .signals  (dec_signals),
        .alu_ctrl (dec_alu_ctrl),
        .imm      (dec_imm),
        .rs       (dec_rs),
        .rt       (dec_rt),
        .wreg     (dec_wreg),
        .illegal  (dec_illegal)
    );

    // lw and j do not read rt, so a match there is not a load-use dependency.
    assign hazard = ex_mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == dec_rs) ||
                     ((ex_rt == dec_rt) && (bus.in_instr[31:26] != OP_LW) &&
                      (bus.in_instr[31:26] != OP_J)));

    assign in_ready_w = rst_n &&
                        ((state == ST_EMPTY) || ((state == ST_FULL) && bus.out_ready)) &&
                        !hazard && !flush;
    assign accept     = bus.in_valid && in_ready_w;

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY, ST_FULL: begin
                    // A FULL stage that is not drained keeps its instruction.
                    if ((state == ST_EMPTY) || bus.out_ready) begin
                        if (accept)                         state_nxt = ST_FULL;
                        else if (bus.in_valid && hazard)    state_nxt = ST_HOLD;
                        else                                state_nxt = ST_EMPTY;
                    end
                end
                ST_HOLD: state_nxt = ST_EMPTY;
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_EMPTY;
            pc_q       <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            wreg_q     <= '0;
            imm_q      <= '0;
            alu_ctrl_q <= '0;
            signals_q  <= '0;
            illegal_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                pc_q       <= bus.in_pc;
                rs_q       <= dec_rs;
                rt_q       <= dec_rt;
                wreg_q     <= dec_wreg;
                imm_q      <= dec_imm;
                alu_ctrl_q <= dec_alu_ctrl;
                signals_q  <= dec_signals;
                illegal_q  <= dec_illegal;
            end
        end
    end

`ifdef DECODE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 16'd0;
        end else if (((state == ST_HOLD) || ((state == ST_FULL) && !bus.out_ready)) &&
                     (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

    assign bus.in_ready     = in_ready_w;
    assign bus.out_valid    = (state == ST_FULL);
    assign bus.out_pc       = pc_q;
    assign bus.out_rs       = rs_q;
    assign bus.out_rt       = rt_q;
    assign bus.out_wreg     = wreg_q;
    assign bus.out_imm      = imm_q;
    assign bus.out_alu_ctrl = alu_ctrl_q;
    assign bus.out_signals  = signals_q;
    assign bus.out_illegal  = illegal_q;
    assign dbg_state        = state;
endmodule
